// File: rtl/uart_instruction_packer_if.sv
// Byte-in / word-out bus between the UART receiver, the instruction packer and the instruction FIFO.
// The master modport is the packer; the slave modport is the surrounding receiver/FIFO side.
interface uart_instruction_packer_if #(
    parameter int unsigned BYTES_PER_INST = 4
);
    localparam int unsigned WORD_W = 8 * BYTES_PER_INST;

    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              fifo_full;
    logic              clr_overflow;
    logic              fifo_wr;
    logic [WORD_W-1:0] fifo_data;
    logic              busy;
    logic              overflow;
    logic              timeout_err;

    modport master (
        input  rx_valid,
        input  rx_data,
        input  fifo_full,
        input  clr_overflow,
        output fifo_wr,
        output fifo_data,
        output busy,
        output overflow,
        output timeout_err
    );

    modport slave (
        output rx_valid,
        output rx_data,
        output fifo_full,
        output clr_overflow,
        input  fifo_wr,
        input  fifo_data,
        input  busy,
        input  overflow,
        input  timeout_err
    );
endinterface

// File: rtl/uart_instruction_packer.sv
// Packs UART bytes (MSB first) into instruction words and pushes them into the instruction FIFO,
// honouring fifo_full and dropping partial words after an inter-byte timeout.
module uart_instruction_packer #(
    parameter int unsigned BYTES_PER_INST = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned TO_W           = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    uart_instruction_packer_if.master bus
);
    localparam int unsigned WORD_W = 8 * BYTES_PER_INST;
    localparam int unsigned CNT_W  = $clog2(BYTES_PER_INST + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] PUSH    = 2'd2;

    logic [1:0]        state_q,  state_nxt;
    logic [CNT_W-1:0]  count_q,  count_nxt;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_nxt;
    logic [WORD_W-1:0] sr_q,     sr_nxt;
    logic [WORD_W-1:0] data_q,   data_nxt;
    logic              wr_q,     wr_nxt;
    logic              ovf_q,    ovf_nxt;
    logic              tmo_q,    tmo_nxt;
    logic              ovf_set;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            to_cnt_q <= '0;
            sr_q     <= '0;
            data_q   <= '0;
            wr_q     <= 1'b0;
            ovf_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            count_q  <= count_nxt;
            to_cnt_q <= to_cnt_nxt;
            sr_q     <= sr_nxt;
            data_q   <= data_nxt;
            wr_q     <= wr_nxt;
            ovf_q    <= ovf_nxt;
            tmo_q    <= tmo_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt  = state_q;
        count_nxt  = count_q;
        to_cnt_nxt = to_cnt_q;
        sr_nxt     = sr_q;
        data_nxt   = data_q;
        wr_nxt     = 1'b0;
        tmo_nxt    = 1'b0;
        ovf_set    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.rx_valid) begin
                    sr_nxt     = WORD_W'(bus.rx_data);
                    count_nxt  = CNT_W'(1);
                    to_cnt_nxt = '0;
                    state_nxt  = COLLECT;
                end
            end

            COLLECT: begin
                // An arriving byte always beats an expiring timer
                if (bus.rx_valid) begin
                    sr_nxt     = {sr_q[WORD_W-9:0], bus.rx_data};
                    count_nxt  = count_q + CNT_W'(1);
                    to_cnt_nxt = '0;
                    if (count_q == CNT_W'(BYTES_PER_INST - 1)) begin
                        state_nxt = PUSH;
                    end
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo_nxt    = 1'b1;
                    sr_nxt     = '0;
                    count_nxt  = '0;
                    to_cnt_nxt = '0;
                    state_nxt  = IDLE;
                end else begin
                    to_cnt_nxt = to_cnt_q + TO_W'(1);
                end
            end

            PUSH: begin
                if (!bus.fifo_full) begin
                    data_nxt   = sr_q;
                    wr_nxt     = 1'b1;
                    to_cnt_nxt = '0;
                    // A byte landing in the write cycle starts the next word
                    if (bus.rx_valid) begin
                        sr_nxt    = WORD_W'(bus.rx_data);
                        count_nxt = CNT_W'(1);
                        state_nxt = COLLECT;
                    end else begin
                        count_nxt = '0;
                        state_nxt = IDLE;
                    end
                end else if (bus.rx_valid) begin
                    ovf_set = 1'b1;
                end
            end

            default: begin
                state_nxt  = IDLE;
                count_nxt  = '0;
                to_cnt_nxt = '0;
            end
        endcase

        // Set has priority over clear
        if (ovf_set) begin
            ovf_nxt = 1'b1;
        end else if (bus.clr_overflow) begin
            ovf_nxt = 1'b0;
        end else begin
            ovf_nxt = ovf_q;
        end
    end

    assign bus.fifo_wr     = wr_q;
    assign bus.fifo_data   = data_q;
    assign bus.overflow    = ovf_q;
    assign bus.timeout_err = tmo_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: doc/uart_instruction_packer.md
Name: uart_instruction_packer

Overview:
Write-side producer for the instruction FIFO that the control unit drains between screen refreshes. Takes bytes from the UART receiver and packs each group of BYTES_PER_INST bytes into one instruction word. Pushes each word into the FIFO with a single-cycle write strobe and respects fifo_full backpressure. Discards partial instructions after an inter-byte timeout so the byte stream resynchronises.

Parameters:
BYTES_PER_INST, 4, bytes per instruction word; legal range 2..8.
TIMEOUT_CYCLES, 50000, idle clk cycles allowed between bytes of one instruction before the partial word is discarded.
TO_W, 16, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  asynchronous, active-low reset.
rx_valid  input  1  one-cycle strobe; rx_data holds a received byte.
rx_data  input  8  received byte; sampled only when rx_valid=1.
fifo_full  input  1  instruction FIFO full flag.
clr_overflow  input  1  clears the sticky overflow flag.
fifo_wr  output  1  FIFO write strobe; high for exactly one cycle per word.
fifo_data  output  8*BYTES_PER_INST  packed instruction word; the first received byte is the most significant.
busy  output  1  high whenever state is not IDLE.
overflow  output  1  sticky; set when a byte is dropped.
timeout_err  output  1  one-cycle pulse when a partial word is discarded.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE; byte count, timeout counter and shift register cleared.
  - fifo_wr=0, fifo_data=0, overflow=0, timeout_err=0.
  - Reset mid-collection or mid-push abandons the word; no write is issued.
- Registered outputs: fifo_wr, fifo_data, overflow and timeout_err are registered. busy is decoded from state.
- States: IDLE, COLLECT, PUSH.
- IDLE:
  - rx_valid=1: shift in the byte, count=1, go to COLLECT, clear the timeout counter.
- COLLECT:
  - rx_valid=1: shift in the byte, count+1, clear the timeout counter.
  - If count reaches BYTES_PER_INST, go to PUSH.
  - rx_valid=0: increment the timeout counter.
  - When the counter equals TIMEOUT_CYCLES-1 with rx_valid=0: pulse timeout_err for 1 cycle, discard the partial word, go to IDLE.
  - rx_valid=1 in the expiry cycle: the byte wins. It is accepted, the counter is cleared and there is no error.
- PUSH:
  - fifo_full=0: on that edge copy the shift register to fifo_data, set fifo_wr=1 for the following cycle, go to IDLE.
  - fifo_full=1: stay in PUSH and hold the word. There is no timeout in PUSH.
- Latency: the last byte is sampled at edge N and the state becomes PUSH. With the FIFO not full, fifo_wr=1 during the cycle after edge N+1, i.e. 2 cycles after the last byte.
- fifo_data is stable from the write cycle until the next push; it is never 'x' after reset.
- Byte arriving in PUSH:
  - fifo_full=0 in the same cycle: the byte becomes byte 0 of the next word; state goes to COLLECT with count=1 while the current word is written.
  - fifo_full=1: the byte is dropped and overflow is set.
- overflow: a set event and clr_overflow in the same cycle leaves overflow=1 (set wins).
- Back-to-back bytes every cycle are supported. Sustained throughput is one word per BYTES_PER_INST cycles with no byte loss while the FIFO is not full.
- fifo_wr is never asserted while fifo_full=1 was sampled at the deciding edge.

Test Plan:
- Nominal word: reset, send 0xA1, 0xB2, 0xC3, 0xD4 with gaps of 3 cycles, FIFO not full -> one fifo_wr pulse 2 cycles after 0xD4, fifo_data=0xA1B2C3D4, busy returns to 0.
- Back-to-back words: send 8 bytes 0x01..0x08 on consecutive cycles -> two one-cycle fifo_wr pulses carrying 0x01020304 and 0x05060708; overflow stays 0.
- Backpressure: hold fifo_full=1 during the 4th-byte push, release after 10 cycles -> fifo_wr occurs only after release, with the word intact. Send 0x55 while full -> dropped, overflow=1. Pulse clr_overflow -> overflow=0. If clr_overflow coincides with a drop -> overflow stays 1.
- Timeout (TIMEOUT_CYCLES=8): send 0x11, 0x22, then idle -> timeout_err pulses exactly 8 cycles after 0x22 and no write occurs. Then send 0x33, 0x44, 0x55, 0x66 -> fifo_data=0x33445566. Also deliver a byte exactly in the expiry cycle -> no timeout_err, the byte is accepted.
- Push-cycle overlap: byte 0x77 arrives in the PUSH cycle with fifo_full=0 -> the current word is written and 0x77 becomes the MSB of the next word.
- Reset mid-operation: assert reset after 2 bytes, release, send 4 new bytes -> only the new word is written; all outputs are 0 during reset.
